// File: rtl/npusch_dmrs_scheduler_pkg.sv
// Shared definitions for the single-tone NPUSCH DMRS/data scheduler:
// format codes, slot geometry, FSM state encoding and the DMRS symbol decode.
package npusch_pkg;

    localparam logic NPUSCH_FMT1 = 1'b0;
    localparam logic NPUSCH_FMT2 = 1'b1;

    localparam int SYM_PER_SLOT = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Format 1 carries DMRS on symbol 3 only; format 2 on symbols 2..4.
    function automatic logic is_dmrs_sym(input logic fmt, input logic [2:0] sym);
        if (fmt == NPUSCH_FMT2) begin
            return (sym >= 3'd2) && (sym <= 3'd4);
        end
        return sym == 3'd3;
    endfunction

endpackage

// File: rtl/npusch_sym_counter.sv
// Symbol/slot/DMRS-index position tracker for the NPUSCH scheduler.
// Ports: clk, rst; clear_i zeroes all counters; adv_i steps one symbol;
// fmt_i/num_slots_i are the latched block settings; sym_o, slot_o,
// dmrs_idx_o give the position; is_dmrs_o/is_last_o decode it.
module npusch_sym_counter
    import npusch_pkg::*;
#(
    parameter int SLOT_W       = 16,
    parameter int SYM_PER_SLOT = npusch_pkg::SYM_PER_SLOT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              adv_i,
    input  logic              fmt_i,
    input  logic [SLOT_W-1:0] num_slots_i,
    output logic [2:0]        sym_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic [SLOT_W-1:0] dmrs_idx_o,
    output logic              is_dmrs_o,
    output logic              is_last_o
);

    localparam logic [2:0] SYM_LAST = 3'(SYM_PER_SLOT - 1);

    logic [2:0]        sym_q, sym_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W-1:0] idx_q, idx_d;

    assign is_dmrs_o  = is_dmrs_sym(fmt_i, sym_q);
    assign is_last_o  = (sym_q == SYM_LAST) &&
                        (slot_q == num_slots_i - SLOT_W'(1));
    assign sym_o      = sym_q;
    assign slot_o     = slot_q;
    assign dmrs_idx_o = idx_q;

    always_comb begin
        sym_d  = sym_q;
        slot_d = slot_q;
        idx_d  = idx_q;
        if (adv_i) begin
            if (is_dmrs_o) begin
                idx_d = idx_q + SLOT_W'(1);
            end
            if (sym_q == SYM_LAST) begin
                sym_d  = 3'd0;
                slot_d = slot_q + SLOT_W'(1);
            end else begin
                sym_d = sym_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            sym_q  <= 3'd0;
            slot_q <= '0;
            idx_q  <= '0;
        end else begin
            sym_q  <= sym_d;
            slot_q <= slot_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/npusch_dmrs_scheduler.sv
// Single-tone NPUSCH symbol scheduler: per symbol picks a DMRS or data
// sample and emits an ordered, position-tagged valid/ready output stream.
// Ports: clk/rst (sync, active-high); start/abort/npusch_fmt/num_slots
// control; busy/done status; dmrs_* and data_* source handshakes with
// dmrs_idx request index; out_* registered output stream.
module npusch_dmrs_scheduler
    import npusch_pkg::*;
#(
    parameter int SAMPLE_W     = 32,
    parameter int SLOT_W       = 16,
    parameter int SYM_PER_SLOT = npusch_pkg::SYM_PER_SLOT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                npusch_fmt,
    input  logic [SLOT_W-1:0]   num_slots,
    output logic                busy,
    output logic                done,
    input  logic [SAMPLE_W-1:0] dmrs_i,
    input  logic [SAMPLE_W-1:0] dmrs_q,
    input  logic                dmrs_valid,
    output logic                dmrs_ready,
    output logic [SLOT_W-1:0]   dmrs_idx,
    input  logic [SAMPLE_W-1:0] data_i,
    input  logic [SAMPLE_W-1:0] data_q,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [SAMPLE_W-1:0] out_i,
    output logic [SAMPLE_W-1:0] out_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_is_dmrs,
    output logic [2:0]          out_sym,
    output logic [SLOT_W-1:0]   out_slot,
    output logic                out_last
);

    state_e              state_q, state_d;
    logic                fmt_q, fmt_d;
    logic [SLOT_W-1:0]   ns_q, ns_d;
    logic                done_q, done_d;
    logic                ov_q, ov_d;
    logic [SAMPLE_W-1:0] oi_q, oi_d;
    logic [SAMPLE_W-1:0] oq_q, oq_d;
    logic                odm_q, odm_d;
    logic [2:0]          osym_q, osym_d;
    logic [SLOT_W-1:0]   oslot_q, oslot_d;
    logic                olast_q, olast_d;

    logic              cnt_clr;
    logic              accept;
    logic              run;
    logic              can_load;
    logic              sel_valid;
    logic [2:0]        sym;
    logic [SLOT_W-1:0] slot;
    logic              is_dmrs;
    logic              is_last;

    npusch_sym_counter #(
        .SLOT_W       (SLOT_W),
        .SYM_PER_SLOT (SYM_PER_SLOT)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (cnt_clr),
        .adv_i       (accept),
        .fmt_i       (fmt_q),
        .num_slots_i (ns_q),
        .sym_o       (sym),
        .slot_o      (slot),
        .dmrs_idx_o  (dmrs_idx),
        .is_dmrs_o   (is_dmrs),
        .is_last_o   (is_last)
    );

    // Output register may load when empty or being drained this cycle.
    assign run       = (state_q == ST_RUN);
    assign can_load  = !ov_q || out_ready;
    assign sel_valid = is_dmrs ? dmrs_valid : data_valid;

    assign dmrs_ready = run && can_load && is_dmrs;
    assign data_ready = run && can_load && !is_dmrs;
    assign accept     = run && can_load && sel_valid && !abort;

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign out_valid   = ov_q;
    assign out_i       = oi_q;
    assign out_q       = oq_q;
    assign out_is_dmrs = odm_q;
    assign out_sym     = osym_q;
    assign out_slot    = oslot_q;
    assign out_last    = olast_q;

    always_comb begin
        state_d = state_q;
        fmt_d   = fmt_q;
        ns_d    = ns_q;
        done_d  = 1'b0;
        ov_d    = ov_q;
        oi_d    = oi_q;
        oq_d    = oq_q;
        odm_d   = odm_q;
        osym_d  = osym_q;
        oslot_d = oslot_q;
        olast_d = olast_q;
        cnt_clr = 1'b0;

        if (abort) begin
            // Any sample taken this cycle is dropped with the block.
            state_d = ST_IDLE;
            ov_d    = 1'b0;
            olast_d = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        fmt_d   = npusch_fmt;
                        ns_d    = num_slots;
                        cnt_clr = 1'b1;
                        if (num_slots == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        ov_d    = 1'b1;
                        oi_d    = is_dmrs ? dmrs_i : data_i;
                        oq_d    = is_dmrs ? dmrs_q : data_q;
                        odm_d   = is_dmrs;
                        osym_d  = sym;
                        oslot_d = slot;
                        olast_d = is_last;
                        if (is_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else if (ov_q && out_ready) begin
                        ov_d    = 1'b0;
                        olast_d = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (ov_q && out_ready) begin
                        ov_d    = 1'b0;
                        olast_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ov_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fmt_q   <= NPUSCH_FMT1;
            ns_q    <= '0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            oi_q    <= '0;
            oq_q    <= '0;
            odm_q   <= 1'b0;
            osym_q  <= 3'd0;
            oslot_q <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            ns_q    <= ns_d;
            done_q  <= done_d;
            ov_q    <= ov_d;
            oi_q    <= oi_d;
            oq_q    <= oq_d;
            odm_q   <= odm_d;
            osym_q  <= osym_d;
            oslot_q <= oslot_d;
            olast_q <= olast_d;
        end
    end

endmodule

// File: tb/tb_npusch_dmrs_scheduler.sv
// Directed bench for npusch_dmrs_scheduler: scenario table plus
// hand-written zero-slot and abort sequences.
module tb_npusch_dmrs_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        npusch_fmt;
    logic [15:0] num_slots;
    logic        busy;
    logic        done;
    logic [31:0] dmrs_i, dmrs_q;
    logic        dmrs_valid;
    logic        dmrs_ready;
    logic [15:0] dmrs_idx;
    logic [31:0] data_i, data_q;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] out_i, out_q;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_dmrs;
    logic [2:0]  out_sym;
    logic [15:0] out_slot;
    logic        out_last;

    npusch_dmrs_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .npusch_fmt  (npusch_fmt),
        .num_slots   (num_slots),
        .busy        (busy),
        .done        (done),
        .dmrs_i      (dmrs_i),
        .dmrs_q      (dmrs_q),
        .dmrs_valid  (dmrs_valid),
        .dmrs_ready  (dmrs_ready),
        .dmrs_idx    (dmrs_idx),
        .data_i      (data_i),
        .data_q      (data_q),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .out_i       (out_i),
        .out_q       (out_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_is_dmrs (out_is_dmrs),
        .out_sym     (out_sym),
        .out_slot    (out_slot),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fmt;
        int   ns;
        int   bp_at;
        int   bp_len;
        int   st_at;
        int   st_len;
        int   beats;
        int   ndm;
        int   nda;
    } scen_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic mfmt;
    int   mns;
    int   n_dmrs, n_data, n_beats, n_done;
    int   a_sym, a_slot, b_sym, b_slot, b_dn, b_an;
    int   first_cyc, last_cyc, done_cyc;
    logic hold_pend;
    logic [127:0] hold_v;

    function automatic logic mdl_dmrs(input logic f, input int s);
        if (f) return (s >= 2) && (s <= 4);
        return s == 3;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive_src();
        dmrs_i = 32'hD000_0000 | 32'(n_dmrs);
        dmrs_q = ~(32'hD000_0000 | 32'(n_dmrs));
        data_i = 32'hA000_0000 | 32'(n_data);
        data_q = ~(32'hA000_0000 | 32'(n_data));
    endtask

    task automatic mdl_reset(input logic f, input int ns);
        mfmt = f; mns = ns;
        n_dmrs = 0; n_data = 0; n_beats = 0; n_done = 0;
        a_sym = 0; a_slot = 0; b_sym = 0; b_slot = 0; b_dn = 0; b_an = 0;
        first_cyc = 0; last_cyc = 0; done_cyc = 0;
        hold_pend = 1'b0;
        drive_src();
    endtask

    task automatic step();
        logic dfire, afire, edm, elast;
        logic [31:0] ev;
        logic [127:0] cur;
        @(negedge clk);
        cur = {42'd0, out_i, out_q, out_is_dmrs, out_sym, out_slot,
               out_last, out_valid};
        if (hold_pend) chk("hold", cur, hold_v);
        if (out_valid && !out_ready) begin
            chk("bp_readies", {dmrs_ready, data_ready}, 0);
            hold_pend = 1'b1;
            hold_v = cur;
        end else begin
            hold_pend = 1'b0;
        end
        dfire = dmrs_valid && dmrs_ready;
        afire = data_valid && data_ready;
        if (dfire || afire) begin
            chk("src_order", {dfire, afire},
                {mdl_dmrs(mfmt, a_sym), !mdl_dmrs(mfmt, a_sym)});
            if (dfire) chk("dmrs_idx", dmrs_idx, n_dmrs);
            if (a_sym == 6) begin a_sym = 0; a_slot++; end
            else a_sym++;
        end
        if (out_valid && out_ready) begin
            edm = mdl_dmrs(mfmt, b_sym);
            elast = (b_sym == 6) && (b_slot == mns - 1);
            ev = edm ? (32'hD000_0000 | 32'(b_dn)) : (32'hA000_0000 | 32'(b_an));
            chk("beat", {out_is_dmrs, out_sym, out_slot, out_last, out_i, out_q},
                {edm, 3'(b_sym), 16'(b_slot), elast, ev, ~ev});
            if (edm) b_dn++; else b_an++;
            if (b_sym == 6) begin b_sym = 0; b_slot++; end
            else b_sym++;
            if (n_beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            n_beats++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (dfire) n_dmrs++;
        if (afire) n_data++;
        drive_src();
    endtask

    task automatic run_scen(input scen_t s);
        mdl_reset(s.fmt, s.ns);
        npusch_fmt = s.fmt;
        num_slots  = 16'(s.ns);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 400 && n_done == 0; c++) begin
            out_ready  = !(c >= s.bp_at && c < s.bp_at + s.bp_len);
            dmrs_valid = !(c >= s.st_at && c < s.st_at + s.st_len);
            step();
        end
        out_ready  = 1'b1;
        dmrs_valid = 1'b1;
        step();
        step();
        chk("beats", n_beats, s.beats);
        chk("dmrs_acc", n_dmrs, s.ndm);
        chk("data_acc", n_data, s.nda);
        chk("done_cnt", n_done, 1);
        chk("done_lat", done_cyc - last_cyc, 1);
        chk("dmrs_idx_end", dmrs_idx, s.ndm);
        chk("busy_end", busy, 0);
        if (s.bp_len == 0 && s.st_len == 0)
            chk("span", last_cyc - first_cyc, s.beats - 1);
    endtask

    scen_t tbl[5];

    initial begin
        tbl[0] = '{1'b0, 2, 0, 0, 0, 0, 14, 2, 12};
        tbl[1] = '{1'b1, 1, 0, 0, 0, 0, 7, 3, 4};
        tbl[2] = '{1'b0, 1, 4, 5, 0, 0, 7, 1, 6};
        tbl[3] = '{1'b0, 1, 0, 0, 2, 10, 7, 1, 6};
        tbl[4] = '{1'b1, 2, 9, 5, 3, 4, 14, 6, 8};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        npusch_fmt = 1'b0; num_slots = '0;
        dmrs_valid = 1'b1; data_valid = 1'b1; out_ready = 1'b1;
        mdl_reset(1'b0, 1);
        step(); step(); step();
        chk("reset", {busy, done, dmrs_ready, data_ready, out_valid, out_i,
                      out_q, out_is_dmrs, out_sym, out_slot, out_last,
                      dmrs_idx}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_scen(tbl[i]);

        // zero-slot block
        mdl_reset(1'b0, 0);
        num_slots = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done", {done, busy}, 2'b10);
        step();
        chk("zero_done_end", {done, busy}, 2'b00);
        step();
        chk("zero_no_acc", n_dmrs + n_data, 0);
        chk("zero_done_cnt", n_done, 1);

        // abort at slot1 sym4 of a 3-slot block
        mdl_reset(1'b0, 3);
        npusch_fmt = 1'b0;
        num_slots  = 16'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 100 && !(a_slot == 1 && a_sym == 4); c++) step();
        chk("abort_reach", {a_slot[3:0], a_sym[3:0]}, 8'h14);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_state", {busy, out_valid, dmrs_ready, data_ready}, 0);
        step(); step(); step();
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", busy, 0);

        run_scen(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npusch_dmrs_scheduler.md
Name: npusch_dmrs_scheduler

Overview:
- Single-tone NPUSCH symbol scheduler for the NB-IoT uplink transmitter chain.
- Sits between the DMRS sequence generator and the data modulator, ahead of RE mapping.
- For each symbol of each slot it selects one complex sample, DMRS or data, according to the NPUSCH format's DMRS symbol positions.
- Emits one ordered valid/ready stream tagged with slot and symbol position, and reports completion.

Parameters:
- SAMPLE_W, 32, width of each I and Q sample word
- SLOT_W, 16, width of the slot count and the DMRS index counter
- SYM_PER_SLOT, 7, SC-FDMA symbols per slot (normal CP)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begin a transport block
- abort  in  1  synchronous abort; return to IDLE
- npusch_fmt  in  1  0 = format 1 (DMRS at symbol 3), 1 = format 2 (DMRS at symbols 2,3,4)
- num_slots  in  SLOT_W  slots to emit; sampled on start
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse after the final output beat
- dmrs_i, dmrs_q  in  SAMPLE_W  DMRS sample from the generator
- dmrs_valid  in  1  DMRS sample available
- dmrs_ready  out  1  DMRS sample consumed this cycle when high together with dmrs_valid
- dmrs_idx  out  SLOT_W  index of the next DMRS sample requested
- data_i, data_q  in  SAMPLE_W  modulated data sample
- data_valid  in  1  data sample available
- data_ready  out  1  data sample consumed this cycle when high together with data_valid
- out_i, out_q  out  SAMPLE_W  selected sample
- out_valid  in/out: out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_is_dmrs  out  1  beat carries DMRS
- out_sym  out  3  symbol index 0..6 within the slot
- out_slot  out  SLOT_W  slot index
- out_last  out  1  final beat of the block

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, dmrs_ready, data_ready, out_valid, out_i/q, out_is_dmrs, out_sym, out_slot, out_last, dmrs_idx.
- States and transitions:
  - IDLE: on start, latch npusch_fmt and num_slots, clear sym_cnt, slot_cnt and dmrs_idx. Go to RUN if num_slots != 0. If num_slots == 0, pulse done on the next cycle and stay IDLE.
  - RUN: current symbol is DMRS iff (fmt=0 and sym_cnt=3) or (fmt=1 and sym_cnt in 2..4).
    - Selected source ready = !out_valid | out_ready.
    - Non-selected source ready = 0.
    - The ready signals are combinational from the state and output register.
  - Accept (selected valid & ready):
    - Load out_i/q, out_is_dmrs, out_sym = sym_cnt, out_slot = slot_cnt.
    - Set out_valid = 1.
    - Set out_last when sym_cnt = 6 and slot_cnt = num_slots-1.
    - dmrs_idx increments on each DMRS accept.
    - sym_cnt wraps 6 -> 0 and increments slot_cnt.
    - Accepting the last beat moves the block to DRAIN.
  - If out_valid & out_ready occur with no new accept, out_valid clears. A simultaneous consume and accept gives zero-bubble throughput: one beat per cycle.
  - DRAIN: both source readies are 0. On out_valid & out_ready: clear out_valid, pulse done for one cycle, go to IDLE.
- Output stability: out_* hold stable while out_valid & !out_ready.
- Latency: one cycle from source accept to out_valid.
- start is ignored while busy.
- abort, or rst mid-block:
  - Next cycle: IDLE, out_valid = 0, readies = 0, no done pulse.
  - A sample accepted in the abort cycle is discarded.
  - abort wins over a simultaneous start.
- Counter widths: dmrs_idx and slot_cnt wrap modulo 2^SLOT_W. No saturation is required; num_slots bounds them.
- A stall on the selected source blocks progress. The other source is never consumed out of order.

Decomposition:
- Shared package npusch_pkg holds:
  - NPUSCH_FMT1 / NPUSCH_FMT2 constants
  - SYM_PER_SLOT
  - the state enum (IDLE, RUN, DRAIN)
  - a function is_dmrs_sym(fmt, sym)
- One natural sub-module: npusch_sym_counter. It holds the sym/slot/dmrs_idx counters, the last detection and the is_dmrs decode. The top keeps the FSM and the output register.

Test Plan:
- fmt=0, num_slots=2, both sources always valid, out_ready=1:
  - 14 beats on consecutive cycles.
  - out_is_dmrs high only at (slot0,sym3) and (slot1,sym3).
  - dmrs_idx ends at 2.
  - out_last on beat 14; done one cycle after it.
- fmt=1, num_slots=1:
  - DMRS beats at sym 2,3,4 with dmrs_idx 0,1,2.
  - Data consumed for sym 0,1,5,6 only (4 data_ready&valid events).
- Backpressure: out_ready low for 5 cycles mid-slot.
  - out_* held constant.
  - Both source readies low.
  - No beats lost or duplicated; sample order matches source order.
- Source stall: dmrs_valid low for 10 cycles at sym3.
  - No data consumed meanwhile.
  - Output resumes with the DMRS sample at sym3.
- num_slots=0 start → done pulses next cycle, busy stays 0, no source accepts.
- abort asserted at slot1 sym4 with num_slots=3 → next cycle busy=0 and out_valid=0, no done; a new start then restarts cleanly from slot0 sym0 with dmrs_idx=0.
